// File: rtl/sound_frame_sequencer_pkg.sv
// Shared constants and step decode for the sound frame sequencer.
// Step masks are indexed by the frame step being left when the divider wraps.
package sound_frame_sequencer_pkg;

  localparam int         SND_DIV_512HZ   = 64453;
  localparam int         SND_CNT_W       = 17;
  localparam logic [7:0] SND_LEN_STEPS   = 8'b0101_0101;
  localparam logic [7:0] SND_SWEEP_STEPS = 8'b0100_0100;
  localparam logic [7:0] SND_ENV_STEPS   = 8'b1000_0000;
  localparam logic [2:0] SND_NR52_FIXED  = 3'b111;

  typedef struct packed {
    logic len;
    logic sweep;
    logic env;
  } tick_t;

  function automatic tick_t decode_step(input logic [2:0] step);
    tick_t t;
    t.len   = SND_LEN_STEPS[step];
    t.sweep = SND_SWEEP_STEPS[step];
    t.env   = SND_ENV_STEPS[step];
    return t;
  endfunction

endpackage

// File: rtl/sound_tick_divider.sv
// Modulo-DIV counter with enable and synchronous clear.
// wrap is combinational: high on the enabled cycle where the count is DIV-1.
module sound_tick_divider #(
  parameter int DIV = 64453,
  parameter int W   = 17
) (
  input  logic I_CLK33MHZ,
  input  logic clr,
  input  logic en,
  output logic wrap
);

  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign wrap = en & (cnt == LAST);

  always_ff @(posedge I_CLK33MHZ) begin
    if (clr || wrap) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sound_frame_sequencer.sv
// 512 Hz frame sequencer: length/sweep/envelope strobes plus NR52 power gating.
// Strobes are registered and appear the cycle after the divider wraps.
module sound_frame_sequencer
  import sound_frame_sequencer_pkg::*;
#(
  parameter int DIV_512HZ = SND_DIV_512HZ,
  parameter int NUM_CH    = 4
) (
  input  logic              I_CLK33MHZ,
  input  logic              I_RESET,
  input  logic              I_MASTER_EN,
  input  logic [NUM_CH-1:0] I_CH_ON,
  output logic              O_LEN_TICK,
  output logic              O_SWEEP_TICK,
  output logic              O_ENV_TICK,
  output logic [2:0]        O_STEP,
  output logic              O_APU_CLEAR,
  output logic [7:0]        O_NR52_STATUS
);

  logic       master_q;
  logic       run;
  logic       fall;
  logic       wrap;
  logic       clear_q;
  logic [2:0] step_q;
  tick_t      tick_q;

  // Counting only while power stays on; a falling edge zeroes everything at once.
  assign run  = master_q & I_MASTER_EN;
  assign fall = master_q & ~I_MASTER_EN;

  sound_tick_divider #(
    .DIV (DIV_512HZ),
    .W   (SND_CNT_W)
  ) u_div (
    .I_CLK33MHZ (I_CLK33MHZ),
    .clr        (I_RESET | ~run),
    .en         (run),
    .wrap       (wrap)
  );

  always_ff @(posedge I_CLK33MHZ) begin
    if (I_RESET) begin
      master_q <= 1'b0;
      clear_q  <= 1'b0;
      step_q   <= 3'd0;
      tick_q   <= '0;
    end else begin
      master_q <= I_MASTER_EN;
      clear_q  <= fall;
      tick_q   <= wrap ? decode_step(step_q) : '0;
      if (!run) begin
        step_q <= 3'd0;
      end else if (wrap) begin
        step_q <= step_q + 3'd1;
      end
    end
  end

  assign O_LEN_TICK    = tick_q.len;
  assign O_SWEEP_TICK  = tick_q.sweep;
  assign O_ENV_TICK    = tick_q.env;
  assign O_STEP        = step_q;
  assign O_APU_CLEAR   = clear_q;
  assign O_NR52_STATUS = {master_q, SND_NR52_FIXED, I_CH_ON & {NUM_CH{master_q}}};

endmodule
